// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter: opcode encodings,
// ALU select values and the controller's FSM state type.
package alu_arb_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_ADD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  // SUB reuses the adder; the operand negation happens outside the ALU
  function automatic logic [1:0] op_to_sel(input logic [1:0] op);
    case (op)
      OP_AND:  return SEL_AND;
      OP_OR:   return SEL_OR;
      default: return SEL_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ALU_4bit.sv
// Existing shared ALU datapath: AND/OR/ADD with carry-out; sel 11 is XOR
// and is not used by the arbiter.
module ALU_4bit #(
  parameter int width = 4
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic [1:0]       sel,
  output logic [width-1:0] out,
  output logic             carry
);

  always_comb begin
    out   = '0;
    carry = 1'b0;
    case (sel)
      2'b00:   out = a & b;
      2'b01:   out = a | b;
      2'b10:   {carry, out} = {1'b0, a} + {1'b0, b};
      default: out = a ^ b;
    endcase
  end

endmodule

// File: rtl/alu_arb_rr.sv
// Two-way round-robin picker: when both requesters are valid, the one that
// was not granted last wins; a lone requester always wins.
module alu_arb_rr (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  assign any   = |valid;
  assign grant = (valid == 2'b11) ? ~last_grant : valid[1];

endmodule

// File: rtl/alu_arb_ctrl.sv
// Round-robin controller sharing one ALU_4bit between two requesters.
// Optional ALU_ARB_PERF_EN adds saturating busy/grant counters.
module alu_arb_ctrl #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_a,
  input  logic [width-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_a,
  input  logic [width-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [width-1:0] rsp_out,
  output logic             rsp_carry
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]      busy_cnt,
  output logic [7:0]       grant0_cnt,
  output logic [7:0]       grant1_cnt
`endif
);

  import alu_arb_pkg::*;

  localparam logic [width-1:0] ONE = width'(1);

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant, any;
  logic [width-1:0] lat_a, lat_b;
  logic [1:0]       lat_op;
  logic             lat_id;
  logic [width-1:0] alu_b, alu_out;
  logic             alu_carry;

  alu_arb_rr u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant),
    .any        (any)
  );

  // SUB is a + (~b + 1); the most-negative b wraps onto itself
  assign alu_b = (lat_op == OP_SUB) ? (~lat_b + ONE) : lat_b;

  ALU_4bit #(.width(width)) u_alu (
    .a     (lat_a),
    .b     (alu_b),
    .sel   (op_to_sel(lat_op)),
    .out   (alu_out),
    .carry (alu_carry)
  );

  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          req0_ready = ~grant;
          req1_ready = grant;
          state_nxt  = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= OP_AND;
      lat_id     <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_out    <= '0;
      rsp_carry  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any) begin
        last_grant <= grant;
        lat_a      <= grant ? req1_a  : req0_a;
        lat_b      <= grant ? req1_b  : req0_b;
        lat_op     <= grant ? req1_op : req0_op;
        lat_id     <= grant;
      end
      if (state == EXEC) begin
        rsp_id    <= lat_id;
        rsp_out   <= alu_out;
        rsp_carry <= lat_op[1] & alu_carry;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt   <= '0;
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else begin
      if (state != IDLE && busy_cnt != 16'hFFFF)
        busy_cnt <= busy_cnt + 16'd1;
      if (req0_ready && grant0_cnt != 8'hFF)
        grant0_cnt <= grant0_cnt + 8'd1;
      if (req1_ready && grant1_cnt != 8'hFF)
        grant1_cnt <= grant1_cnt + 8'd1;
    end
  end
`endif

endmodule
